// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_gen_pipe: RV immediate generator with a 2-entry valid/ready output FIFO |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0,
  parameter int TAG_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  // FMT_SHW is the 5-bit shamt of the RV64 word-shift opcode.
  typedef enum logic [3:0] {
    FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z, FMT_SH, FMT_SHW, FMT_ERR
  } fmt_e;

  fmt_e            fmt;
  logic [XLEN-1:0] imm_w;
  logic            err_w;
  logic [2:0]      funct3;
  logic            is_shift;

  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin : p_format
    fmt = FMT_ERR;
    if (AUTO_DECODE) begin
      case (in_instr[6:0])
        7'b0000011, 7'b1100111: fmt = FMT_I;
        7'b0010011:             fmt = is_shift ? FMT_SH : FMT_I;
        7'b0100011:             fmt = FMT_S;
        7'b1100011:             fmt = FMT_B;
        7'b0110111, 7'b0010111: fmt = FMT_U;
        7'b1101111:             fmt = FMT_J;
        7'b1110011:             fmt = funct3[2] ? FMT_Z : FMT_I;
        7'b0011011:             fmt = (XLEN == 64) ? (is_shift ? FMT_SHW : FMT_I) : FMT_ERR;
        default:                fmt = FMT_ERR;
      endcase
    end else begin
      case (in_imm_type)
        3'd0:    fmt = FMT_I;
        3'd1:    fmt = FMT_S;
        3'd2:    fmt = FMT_B;
        3'd3:    fmt = FMT_U;
        3'd4:    fmt = FMT_J;
        3'd5:    fmt = FMT_Z;
        3'd6:    fmt = FMT_SH;
        default: fmt = FMT_ERR;
      endcase
    end
  end

  always_comb begin : p_extend
    imm_w = '0;
    err_w = 1'b0;
    case (fmt)
      FMT_I:   imm_w = XLEN'($signed(in_instr[31:20]));
      FMT_S:   imm_w = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      FMT_B:   imm_w = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                      in_instr[11:8], 1'b0}));
      FMT_U:   imm_w = XLEN'($signed({in_instr[31:12], 12'b0}));
      FMT_J:   imm_w = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                      in_instr[30:21], 1'b0}));
      FMT_Z:   imm_w = XLEN'(in_instr[19:15]);
      FMT_SH:  imm_w = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
      FMT_SHW: imm_w = XLEN'(in_instr[24:20]);
      default: err_w = 1'b1;
    endcase
  end

  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0]  imm_mem_q [2];
  logic [XLEN-1:0]  imm_mem_d [2];
  logic             err_mem_q [2];
  logic             err_mem_d [2];
  logic [TAG_W-1:0] tag_mem_q [2];
  logic [TAG_W-1:0] tag_mem_d [2];
  logic             push;
  logic             pop;

  assign in_ready  = rst_n && (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_imm   = imm_mem_q[rd_ptr_q];
  assign out_err   = err_mem_q[rd_ptr_q];
  assign out_tag   = tag_mem_q[rd_ptr_q];

  always_comb begin : p_fifo_next
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    imm_mem_d = imm_mem_q;
    err_mem_d = err_mem_q;
    tag_mem_d = tag_mem_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        imm_mem_d[wr_ptr_q] = imm_w;
        err_mem_d[wr_ptr_q] = err_w;
        tag_mem_d[wr_ptr_q] = in_tag;
        wr_ptr_d            = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so out_* read as zero while empty after reset.
  always_ff @(posedge clk) begin : p_fifo_regs
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        imm_mem_q[i] <= '0;
        err_mem_q[i] <= 1'b0;
        tag_mem_q[i] <= '0;
      end
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      imm_mem_q <= imm_mem_d;
      err_mem_q <= err_mem_d;
      tag_mem_q <= tag_mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imm_gen_pipe: bench for imm_gen_pipe (XLEN=32 manual, XLEN=64 auto)     |
// | Revision: 1.1                                                              |
// +----------------------------------------------------------------------------+
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush;
    logic        v32, r32, ov32, or32, err32;
    logic [31:0] ins32, imm32;
    logic [2:0]  ty32;
    logic [7:0]  tag32, otag32;
    logic        v64, r64, ov64, or64, err64;
    logic [31:0] ins64;
    logic [63:0] imm64;
    logic [2:0]  ty64;
    logic [7:0]  tag64, otag64;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .TAG_W(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v32), .in_ready(r32), .in_instr(ins32), .in_imm_type(ty32), .in_tag(tag32),
        .out_valid(ov32), .out_ready(or32), .out_imm(imm32), .out_err(err32), .out_tag(otag32)
    );

    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1), .TAG_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v64), .in_ready(r64), .in_instr(ins64), .in_imm_type(ty64), .in_tag(tag64),
        .out_valid(ov64), .out_ready(or64), .out_imm(imm64), .out_err(err64), .out_tag(otag64)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $error("%s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $error("%s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic one32(input string name, input logic [31:0] ins, input logic [2:0] ty,
                         input logic [7:0] tag, input logic [31:0] exp_imm, input logic exp_err);
        v32 = 1'b1; ins32 = ins; ty32 = ty; tag32 = tag; or32 = 1'b1;
        check_bit({name, " in_ready"}, r32, 1'b1);
        @(negedge clk);
        v32 = 1'b0;
        check_bit({name, " out_valid"}, ov32, 1'b1);
        check_val({name, " out_imm"}, {32'd0, imm32}, {32'd0, exp_imm});
        check_bit({name, " out_err"}, err32, exp_err);
        check_val({name, " out_tag"}, {56'd0, otag32}, {56'd0, tag});
        @(negedge clk);
        check_bit({name, " drained"}, ov32, 1'b0);
    endtask

    task automatic one64(input string name, input logic [31:0] ins, input logic [7:0] tag,
                         input logic [63:0] exp_imm, input logic exp_err);
        v64 = 1'b1; ins64 = ins; tag64 = tag; or64 = 1'b1;
        @(negedge clk);
        v64 = 1'b0;
        check_bit({name, " out_valid"}, ov64, 1'b1);
        check_val({name, " out_imm"}, imm64, exp_imm);
        check_bit({name, " out_err"}, err64, exp_err);
        check_val({name, " out_tag"}, {56'd0, otag64}, {56'd0, tag});
        @(negedge clk);
        check_bit({name, " drained"}, ov64, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        v32 = 1'b0; ins32 = '0; ty32 = '0; tag32 = '0; or32 = 1'b0;
        v64 = 1'b0; ins64 = '0; ty64 = '0; tag64 = '0; or64 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_bit("reset in_ready32", r32, 1'b0);
        check_bit("reset out_valid32", ov32, 1'b0);
        check_val("reset out_imm32", {32'd0, imm32}, 64'd0);
        check_bit("reset in_ready64", r64, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        one32("I", 32'hFFF00093, 3'd0, 8'd1, 32'hFFFFFFFF, 1'b0);
        one32("S", 32'hFE20AE23, 3'd1, 8'd2, 32'hFFFFFFFC, 1'b0);
        one32("B", 32'h00000463, 3'd2, 8'd3, 32'h00000008, 1'b0);
        one32("U", 32'h123452B7, 3'd3, 8'd4, 32'h12345000, 1'b0);
        one32("J", 32'hFFDFF06F, 3'd4, 8'd5, 32'hFFFFFFFC, 1'b0);
        one32("Z", 32'h000FD073, 3'd5, 8'd6, 32'h0000001F, 1'b0);
        one32("T7", 32'hFFFFFFFF, 3'd7, 8'd7, 32'h00000000, 1'b1);

        one64("J64", 32'hFFDFF06F, 8'd8, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        one64("SLLI64", 32'h03F09093, 8'd9, 64'h000000000000003F, 1'b0);
        one64("BADOP64", 32'h0000007F, 8'd10, 64'd0, 1'b1);

        or32 = 1'b0;
        v32 = 1'b1; ins32 = 32'h00100093; ty32 = 3'd0; tag32 = 8'd1;
        @(negedge clk);
        v32 = 1'b1; ins32 = 32'h00200093; ty32 = 3'd0; tag32 = 8'd2;
        @(negedge clk);
        v32 = 1'b0;
        check_bit("bp in_ready", r32, 1'b0);
        check_bit("bp out_valid", ov32, 1'b1);
        check_val("bp head tag", {56'd0, otag32}, 64'd1);
        @(negedge clk);
        check_val("bp tag held", {56'd0, otag32}, 64'd1);
        check_val("bp imm held", {32'd0, imm32}, 64'd1);
        or32 = 1'b1;
        @(negedge clk);
        check_bit("bp second valid", ov32, 1'b1);
        check_val("bp second tag", {56'd0, otag32}, 64'd2);
        check_val("bp second imm", {32'd0, imm32}, 64'd2);
        @(negedge clk);
        check_bit("bp drained", ov32, 1'b0);

        for (int i = 0; i < 10; i++) begin
            v32 = 1'b1; ins32 = {12'(i), 20'h00093}; ty32 = 3'd0; tag32 = 8'(10 + i); or32 = 1'b1;
            @(negedge clk);
            check_bit("stream valid", ov32, 1'b1);
            check_val("stream tag", {56'd0, otag32}, 64'(10 + i));
            check_val("stream imm", {32'd0, imm32}, 64'(i));
            check_bit("stream count<=1", r32, 1'b1);
        end
        v32 = 1'b0;
        @(negedge clk);
        check_bit("stream drained", ov32, 1'b0);

        or32 = 1'b0;
        v32 = 1'b1; ins32 = 32'h00100093; ty32 = 3'd0; tag32 = 8'd20;
        @(negedge clk);
        tag32 = 8'd21;
        @(negedge clk);
        check_bit("flush pre full", r32, 1'b0);
        flush = 1'b1; tag32 = 8'd22;
        @(negedge clk);
        flush = 1'b0; v32 = 1'b0;
        check_bit("flush out_valid", ov32, 1'b0);
        check_bit("flush in_ready", r32, 1'b1);

        v32 = 1'b1; ins32 = 32'hFFF00093; tag32 = 8'd30;
        v64 = 1'b1; ins64 = 32'hFFF00093; tag64 = 8'd31; or64 = 1'b0;
        @(negedge clk);
        check_bit("pre-reset valid", ov32, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check_bit("rst out_valid32", ov32, 1'b0);
        check_val("rst out_imm32", {32'd0, imm32}, 64'd0);
        check_bit("rst out_err32", err32, 1'b0);
        check_val("rst out_tag32", {56'd0, otag32}, 64'd0);
        check_bit("rst in_ready32", r32, 1'b0);
        check_bit("rst out_valid64", ov64, 1'b0);
        check_val("rst out_imm64", imm64, 64'd0);
        check_bit("rst in_ready64", r64, 1'b0);
        v32 = 1'b0; v64 = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        if (errors != 0) $fatal(1, "FAIL: %0d errors", errors);
        $finish;
    end

endmodule
`default_nettype wire
